mult_div_unit: RTL and testbench
================================

# mult_div_unit

- Iterative 32-bit multiply/divide unit with HI/LO result registers.
- Sits in the execute stage beside the combinational ALU and consumes the same 5-bit ALUControl encoding that the ALU control decoder produces.
- Executes mult, multu, div and divu over multiple cycles, with a start/busy/done handshake toward the pipeline stall logic.
- All other ALUControl codes belong to the combinational ALU; this unit ignores them.

## Interface
Parameters: none (datapath fixed at 32 bits; iteration count fixed at 32).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request to begin an operation; sampled on clk rising edges
- ALUControl  in  5  operation code: 01001 mult, 01010 multu, 00100 div, 01011 divu
- a  in  32  operand A (multiplicand or dividend)
- b  in  32  operand B (multiplier or divisor)
- busy  out  1  operation in progress; start is ignored while high
- done  out  1  one-cycle pulse; HI/LO hold the new result
- div0  out  1  last completed operation was a divide with b == 0
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
States and transitions:
- IDLE → RUN when start=1 and ALUControl is one of the four codes. This is "accept".
- RUN → FINISH after exactly 32 iterations.
- FINISH → IDLE unconditionally.

At accept:
- Latch the opcode.
- Latch |a| and |b| for signed ops (two's-complement magnitude), or a and b unchanged for unsigned ops.
- Latch the sign flags.
- Clear the 5-bit iteration counter.

RUN, multiply:
- Unsigned shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- For mult, the final 64-bit product is negated when sign(a) xor sign(b).
- Result: hi = product[63:32], lo = product[31:0].

RUN, divide:
- Restoring division on magnitudes, one quotient bit per cycle, MSB first.
- Uses a 33-bit partial remainder; no truncation.
- For div, the quotient is negated when sign(a) xor sign(b), and the remainder is negated when sign(a).
- Result: lo = quotient, hi = remainder.
- Overflow case div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0x00000000 (natural wrap, no flag).

Divide by zero (div or divu with b==0):
- lo=0xFFFFFFFF and hi=a (original a, no sign processing).
- div0=1.
- Still takes the full latency.

FINISH:
- Sign correction.
- At the edge leaving FINISH: write hi, lo and div0, and pulse done.

Other rules:
- Opcode 01001 vs 01010 selects signed vs unsigned; 00100 vs 01011 likewise.
- Unrecognised codes with start=1 produce no acceptance, no busy and no HI/LO change.
- hi, lo and div0 hold their values between operations and change only at completion or reset.

## Timing
- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, div0=0, hi=0, lo=0, counter=0. Applies mid-operation too: the operation is aborted and no done is produced.
- Accept at edge N:
  - busy=1 from after edge N through edge N+33.
  - RUN iterations occur at edges N+1 to N+32.
  - FINISH is the cycle after edge N+32.
  - At edge N+33: hi/lo/div0 update, done=1 for exactly one cycle, busy=0.
- Latency is 33 cycles from accept to result visible.
- start while busy=1 is ignored: no queueing, and the latched operands are not disturbed.
- start in the cycle where done=1 (state IDLE) is accepted; back-to-back throughput is one operation per 34 cycles.
- a, b and ALUControl need only be valid in the accept cycle.
- done and busy are never high together.

## Test plan
- mult a=0xFFFFFFFF b=0x00000002 → at edge N+33: hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulse 1 cycle. multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (−7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7 b=2 → lo=3, hi=1. div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0, div0=0.
- divu a=0x12345678 b=0 → hi=0x12345678, lo=0xFFFFFFFF, div0=1 at edge N+33. A following multu 3×5 → lo=15, hi=0, div0=0.
- Handshake:
  - start with ALUControl=00010 → busy stays 0, hi/lo unchanged.
  - start pulses during busy with different a/b → ignored, result matches the first operation.
  - start in the done cycle → accepted, second done exactly 34 cycles after the first.
- Reset asserted asynchronously at RUN iteration 10 → busy=0 and hi=lo=0 immediately, no done. After deassert, mult 6×7 → lo=42, hi=0 after 33 cycles.
- Randomised signed/unsigned mult/div (≥1000 ops, b≠0 and b=0 mix) compared against a 64-bit reference model; check every done pulse falls exactly 33 cycles after its accept.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit with HI/LO result
// registers. Shift-add multiply (LSB first) and restoring divide (MSB first)
// run on operand magnitudes for 32 cycles; sign correction is applied in the
// FINISH cycle and the result lands in HI/LO on the edge leaving FINISH.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  ALUControl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] OP_MULT  = 5'b01001;
  localparam logic [4:0] OP_MULTU = 5'b01010;
  localparam logic [4:0] OP_DIV   = 5'b00100;
  localparam logic [4:0] OP_DIVU  = 5'b01011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t      state_q;
  logic        busy_q, done_q, div0_q;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q, lo_q;

  // Working datapath registers (not reset; only meaningful while busy)
  logic        is_div_q, sa_q, sb_q, dz_q;
  logic [31:0] ma_q, mb_q, a_raw_q;
  logic [32:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;

  logic [32:0] mul_sum, div_trial, div_diff;
  logic        div_ge;
  logic [63:0] prod;
  logic [31:0] hi_d, lo_d;

  logic op_valid, op_signed, op_div, accept;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic sgn);
    if (sgn && v[31]) return 32'(-v);
    else              return 32'(v);
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

  assign op_signed = (ALUControl == OP_MULT) || (ALUControl == OP_DIV);
  assign op_div    = (ALUControl == OP_DIV)  || (ALUControl == OP_DIVU);
  assign op_valid  = op_signed || (ALUControl == OP_MULTU) || (ALUControl == OP_DIVU);
  assign accept    = (state_q == S_IDLE) && start && op_valid;

  // One iteration: shift-add step for multiply, restoring step for divide.
  // Multiply: acc_hi holds the running upper product, acc_lo the multiplier
  // being shifted out while product bits shift in.
  // Divide: acc_hi holds the partial remainder, acc_lo the dividend being
  // shifted out while quotient bits shift in.
  always_comb begin
    mul_sum   = acc_hi_q + (acc_lo_q[0] ? {1'b0, ma_q} : 33'd0);
    div_trial = {acc_hi_q[31:0], acc_lo_q[31]};
    div_ge    = (div_trial >= {1'b0, mb_q});
    div_diff  = div_trial - {1'b0, mb_q};
    if (is_div_q) begin
      acc_hi_d = div_ge ? div_diff : div_trial;
      acc_lo_d = {acc_lo_q[30:0], div_ge};
    end else begin
      acc_hi_d = {1'b0, mul_sum[32:1]};
      acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
    end
  end

  // Sign correction and divide-by-zero override for the final result
  always_comb begin
    prod = neg64({acc_hi_q[31:0], acc_lo_q}, sa_q ^ sb_q);
    if (!is_div_q) begin
      hi_d = prod[63:32];
      lo_d = prod[31:0];
    end else if (dz_q) begin
      hi_d = a_raw_q;
      lo_d = 32'hFFFF_FFFF;
    end else begin
      hi_d = neg32(acc_hi_q[31:0], sa_q);
      lo_d = neg32(acc_lo_q, sa_q ^ sb_q);
    end
  end

  // Control FSM with registered handshake outputs and HI/LO result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      cnt_q   <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            cnt_q   <= 5'd0;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_FINISH;
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          div0_q  <= is_div_q && dz_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Operand latch at accept, then one iteration per RUN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div_q <= op_div;
      sa_q     <= op_signed && a[31];
      sb_q     <= op_signed && b[31];
      dz_q     <= op_div && (b == 32'd0);
      a_raw_q  <= a;
      ma_q     <= mag32(a, op_signed);
      mb_q     <= mag32(b, op_signed);
      acc_hi_q <= 33'd0;
      acc_lo_q <= op_div ? mag32(a, op_signed) : mag32(b, op_signed);
    end else if (state_q == S_RUN) begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed vector table, handshake corner
// sequences, asynchronous reset abort, and randomised operations checked
// against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

  localparam logic [4:0] OP_MULT  = 5'b01001;
  localparam logic [4:0] OP_MULTU = 5'b01010;
  localparam logic [4:0] OP_DIV   = 5'b00100;
  localparam logic [4:0] OP_DIVU  = 5'b01011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  ctrl = 5'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] last_hi = 32'd0, last_lo = 32'd0;
  logic        last_d0 = 1'b0;
  time         last_done_t = 0;

  logic [4:0] ops [4];

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        d0;
  } vec_t;

  vec_t vecs [9];

  mult_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ALUControl (ctrl),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .div0       (div0),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each operation
  task automatic model(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] h, output logic [31:0] l, output logic d);
    longint      sx, sy, p, q, r;
    logic [63:0] up;
    d = 1'b0;
    h = 32'd0;
    l = 32'd0;
    case (c)
      OP_MULT: begin
        p = longint'($signed(x)) * longint'($signed(y));
        {h, l} = p;
      end
      OP_MULTU: begin
        up = {32'd0, x} * {32'd0, y};
        {h, l} = up;
      end
      OP_DIV: begin
        if (y == 32'd0) begin
          h = x; l = 32'hFFFF_FFFF; d = 1'b1;
        end else begin
          sx = longint'($signed(x));
          sy = longint'($signed(y));
          q = sx / sy;
          r = sx % sy;
          l = q[31:0];
          h = r[31:0];
        end
      end
      OP_DIVU: begin
        if (y == 32'd0) begin
          h = x; l = 32'hFFFF_FFFF; d = 1'b1;
        end else begin
          l = x / y;
          h = x % y;
        end
      end
      default: ;
    endcase
  endtask

  // Issue one operation (caller is mid-cycle), optionally pulse start with
  // junk operands while busy, and check latency, handshake and result.
  task automatic run_op(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y,
                        input bit noise, input string nm);
    logic [31:0] eh, el;
    logic        ed;
    int          lat;
    bit          seen, busy_ok;
    model(c, x, y, eh, el, ed);
    start = 1'b1; ctrl = c; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; ctrl = 5'($urandom);
    lat = 0; seen = 1'b0; busy_ok = (busy === 1'b1) && (done === 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (noise) begin
        start = i[0];
        ctrl  = ops[$urandom_range(0, 3)];
        a     = $urandom;
        b     = $urandom;
      end
    end
    start = 1'b0;
    last_done_t = $time;
    chk({nm, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      chk({nm, "_latency"}, lat, 33);
      chk({nm, "_busy_during"}, busy_ok, 1'b1);
      chk({nm, "_busy_at_done"}, busy, 1'b0);
      chk({nm, "_hi"}, hi, eh);
      chk({nm, "_lo"}, lo, el);
      chk({nm, "_div0"}, div0, ed);
    end
    last_hi = eh; last_lo = el; last_d0 = ed;
  endtask

  initial begin
    bit          seen;
    time         t1;
    logic [4:0]  rc;
    logic [31:0] ra, rb;

    ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5] = '{OP_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{OP_MULTU, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0};
    vecs[7] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

    // Asynchronous reset, checked before any clock edge samples it
    #3 reset = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_div0", div0, 1'b0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, 1'b0, "vec");
      chk("vec_tbl_hi", hi, vecs[i].hi);
      chk("vec_tbl_lo", lo, vecs[i].lo);
      chk("vec_tbl_div0", div0, vecs[i].d0);
      @(posedge clk); #1;
      chk("vec_done_width", done, 1'b0);
    end

    // Unrecognised opcode: no accept, no HI/LO change
    start = 1'b1; ctrl = 5'b00010; a = 32'hDEAD_BEEF; b = 32'h0000_1234;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("badop_busy", busy, 1'b0);
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("badop_done", done, 1'b0);
    chk("badop_hi", hi, last_hi);
    chk("badop_lo", lo, last_lo);
    chk("badop_div0", div0, last_d0);

    // start pulses while busy must not disturb the running operation
    run_op(OP_MULTU, 32'd1000, 32'd1000, 1'b1, "noise");
    chk("noise_lo", lo, 32'd1000000);
    run_op(OP_DIV, 32'hFFFF_FC18, 32'd7, 1'b1, "noise_div");

    // start in the done cycle: accepted, next done 34 cycles later
    run_op(OP_MULT, 32'd12, 32'hFFFF_FFFD, 1'b0, "b2b_a");
    t1 = last_done_t;
    run_op(OP_DIVU, 32'd100, 32'd9, 1'b0, "b2b_b");
    chk("b2b_spacing", 64'(last_done_t - t1), 64'd340);

    // Asynchronous reset at RUN iteration 10 aborts the operation
    start = 1'b1; ctrl = OP_MULT; a = 32'h0001_2345; b = 32'h0000_6789;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_div0", div0, 1'b0);
    last_hi = 32'd0; last_lo = 32'd0; last_d0 = 1'b0;
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", seen, 1'b0);
    run_op(OP_MULT, 32'd6, 32'd7, 1'b0, "post_rst");
    chk("post_rst_lo", lo, 32'd42);
    chk("post_rst_hi", hi, 32'd0);

    // Randomised operations against the reference model
    for (int n = 0; n < 1000; n++) begin
      rc = ops[$urandom_range(0, 3)];
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(rc, ra, rb, 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
